// File: rtl/reservoir_sensor_filter.sv
// Reservoir level-sensor conditioner: 2-flop sync, per-bit debounce, thermometer-code check,
// bounded HOLD then sticky FAULT (forces 000). Optional stats: RESERVOIR_SENSOR_FILTER_STATS_EN.

module reservoir_sensor_filter_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  ,
  output logic glitch_o
`endif
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  // A partially-qualified run that falls back to the stable value is a rejected glitch.
  assign glitch_o = (cnt_q != '0) && (sync2_q == stable_q);
`endif
endmodule

module reservoir_sensor_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FAULT_LIMIT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] raw,
  input  logic       fault_clr,
  output logic [2:0] s,
  output logic       valid,
  output logic       fault,
  output logic       change
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);
  localparam int unsigned NUM_BITS = 3;
  localparam int unsigned ILL_W    = $clog2(FAULT_LIMIT + 1);
  localparam int unsigned INIT_W   = $clog2(DEBOUNCE_CYCLES + 2);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HOLD, ST_FAULT} state_e;

  logic [NUM_BITS-1:0] stable;
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  logic [NUM_BITS-1:0] glitch;
`endif

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    reservoir_sensor_filter_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (raw[i]),
      .stable_o (stable[i])
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
      ,
      .glitch_o (glitch[i])
`endif
    );
  end

  logic stable_legal;
  assign stable_legal = (stable == 3'b000) || (stable == 3'b001) ||
                        (stable == 3'b011) || (stable == 3'b111);

  state_e            state_q, state_d;
  logic [2:0]        s_q, s_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              change_q, change_d;
  logic [ILL_W-1:0]  ill_cnt_q, ill_cnt_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    ill_cnt_d  = ill_cnt_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        s_d = 3'b000;
        // Wait out sync + one full debounce window before trusting stable.
        if (init_cnt_q == INIT_W'(DEBOUNCE_CYCLES + 1)) begin
          init_cnt_d = '0;
          ill_cnt_d  = '0;
          if (stable_legal) begin
            state_d = ST_RUN;
            s_d     = stable;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        ill_cnt_d = '0;
        if (stable_legal) s_d = stable;
        else              state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stable_legal) begin
          state_d   = ST_RUN;
          s_d       = stable;
          ill_cnt_d = '0;
        end else if (ill_cnt_q == ILL_W'(FAULT_LIMIT - 1)) begin
          state_d   = ST_FAULT;
          s_d       = 3'b000;
          ill_cnt_d = '0;
        end else begin
          ill_cnt_d = ill_cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        s_d = 3'b000;
        if (fault_clr && stable_legal) begin
          state_d = ST_RUN;
          s_d     = stable;
        end
      end
      default: state_d = ST_INIT;
    endcase
    valid_d  = (state_d == ST_RUN);
    fault_d  = (state_d == ST_FAULT);
    change_d = (s_d != s_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      s_q        <= 3'b000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      change_q   <= 1'b0;
      ill_cnt_q  <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      change_q   <= change_d;
      ill_cnt_q  <= ill_cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign s      = s_q;
  assign valid  = valid_q;
  assign fault  = fault_q;
  assign change = change_q;

`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if ((|glitch) && (glitch_cnt_q != 8'hFF)) glitch_cnt_d = glitch_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) glitch_cnt_q <= 8'd0;
    else       glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt = glitch_cnt_q;
`endif
endmodule

// File: tb/tb_reservoir_sensor_filter.sv
// Bench for reservoir_sensor_filter: directed scenarios with fixed expectations, then random
// sensor traffic checked cycle-by-cycle against a sample-history reference model.

module tb_reservoir_sensor_filter;
  localparam int D  = 4;
  localparam int FL = 3;
  localparam int M_INIT = 0, M_RUN = 1, M_HOLD = 2, M_FAULT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] raw = 3'b000;
  logic       fault_clr = 1'b0;
  logic [2:0] s;
  logic       valid, fault, change;
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
  logic [7:0] glitch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reservoir_sensor_filter #(.DEBOUNCE_CYCLES(D), .FAULT_LIMIT(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .raw       (raw),
    .fault_clr (fault_clr),
    .s         (s),
    .valid     (valid),
    .fault     (fault),
    .change    (change)
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int         m_mode, m_edges, m_bad, m_glitch;
  logic [2:0] m_sync1, m_sync2, m_stable, m_s;
  logic       m_valid, m_fault, m_change;
  bit         hist [3][$];

  function automatic bit is_legal(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
  endfunction

  task automatic model_step(input logic [2:0] r, input logic clr, input logic rst);
    logic [2:0] old_stable;
    logic [2:0] new_s;
    bit         lg, flip, any_glitch;
    if (rst) begin
      m_mode = M_INIT; m_edges = 0; m_bad = 0; m_glitch = 0;
      m_sync1 = 0; m_sync2 = 0; m_stable = 0; m_s = 0;
      m_valid = 0; m_fault = 0; m_change = 0;
      for (int i = 0; i < 3; i++) hist[i].delete();
      return;
    end
    m_edges++;
    old_stable = m_stable;
    lg = is_legal(old_stable);
    new_s = m_s;
    case (m_mode)
      M_INIT: begin
        new_s = 0;
        if (m_edges == D + 2) begin
          m_bad = 0;
          if (lg) begin m_mode = M_RUN; new_s = old_stable; end
          else m_mode = M_HOLD;
        end
      end
      M_RUN: begin
        if (lg) new_s = old_stable;
        else begin m_mode = M_HOLD; m_bad = 0; end
      end
      M_HOLD: begin
        if (lg) begin m_mode = M_RUN; new_s = old_stable; end
        else begin
          m_bad++;
          if (m_bad == FL) begin m_mode = M_FAULT; new_s = 0; end
        end
      end
      default: begin
        new_s = 0;
        if (clr && lg) begin m_mode = M_RUN; new_s = old_stable; end
      end
    endcase
    m_change = (new_s != m_s);
    m_s      = new_s;
    m_valid  = (m_mode == M_RUN);
    m_fault  = (m_mode == M_FAULT);
    // A bit flips once its last D synchronised samples all disagree with it.
    any_glitch = 0;
    for (int i = 0; i < 3; i++) begin
      hist[i].push_back(m_sync2[i]);
      if (hist[i].size() > D) void'(hist[i].pop_front());
      flip = (hist[i].size() == D);
      for (int j = 0; j < hist[i].size(); j++)
        if (hist[i][j] == old_stable[i]) flip = 0;
      if (flip) m_stable[i] = ~old_stable[i];
      if (hist[i].size() >= 2 && hist[i][hist[i].size()-1] == old_stable[i] &&
          hist[i][hist[i].size()-2] != old_stable[i]) any_glitch = 1;
    end
    if (any_glitch && m_glitch < 255) m_glitch++;
    m_sync2 = m_sync1;
    m_sync1 = r;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    logic [5:0] exp;
    @(negedge clk); reset = 1; raw = 3'b000; fault_clr = 0;
    repeat (3) tick();
    n_checks++;
    if ({s, valid, fault, change} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL reset_values got s/v/f/c=%b want %b", {s, valid, fault, change}, 6'b0);
    end
    @(negedge clk); reset = 0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = {3'b000, (n >= 6), 1'b0, 1'b0};
      n_checks++;
      if ({s, valid, fault, change} !== exp) begin
        n_fail++;
        $display("FAIL init_release edge=%0d got s/v/f/c=%b want %b", n, {s, valid, fault, change}, exp);
      end
    end
  endtask

  task automatic test_step();
    logic [5:0] exp;
    @(negedge clk); raw = 3'b001;
    for (int k = 0; k <= 8; k++) begin
      tick();
      exp = {(k >= 6) ? 3'b001 : 3'b000, 1'b1, 1'b0, (k == 6)};
      n_checks++;
      if ({s, valid, fault, change} !== exp) begin
        n_fail++;
        $display("FAIL step_001 edge=%0d got s/v/f/c=%b want %b", k, {s, valid, fault, change}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int w;
    for (int p = 0; p < 2; p++) begin
      w = (p == 0) ? 1 : 3;
      @(negedge clk); raw = 3'b000;
      for (int c = 0; c < w; c++) tick();
      @(negedge clk); raw = 3'b001;
      for (int c = 0; c < 8; c++) begin
        tick();
        n_checks++;
        if ({s, valid, fault, change} !== 6'b001_100) begin
          n_fail++;
          $display("FAIL glitch_w%0d cyc=%0d got s/v/f/c=%b want %b", w, c, {s, valid, fault, change}, 6'b001_100);
        end
      end
    end
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
    n_checks++;
    if (glitch_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL glitch_cnt got %0d want 2", glitch_cnt);
    end
`endif
  endtask

  task automatic test_hold_fault();
    logic [5:0] exp;
    @(negedge clk); raw = 3'b101;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k < 6)      exp = 6'b001_100;
      else if (k < 9) exp = 6'b001_000;
      else            exp = 6'b000_011;
      n_checks++;
      if ({s, valid, fault, change} !== exp) begin
        n_fail++;
        $display("FAIL hold_to_fault edge=%0d got s/v/f/c=%b want %b", k, {s, valid, fault, change}, exp);
      end
    end
    @(negedge clk); fault_clr = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({s, valid, fault, change} !== 6'b000_010) begin
        n_fail++;
        $display("FAIL clr_while_illegal cyc=%0d got s/v/f/c=%b want %b", k, {s, valid, fault, change}, 6'b000_010);
      end
    end
    @(negedge clk); fault_clr = 0;
  endtask

  task automatic test_fault_recover();
    @(negedge clk); raw = 3'b011;
    for (int k = 0; k <= 7; k++) begin
      tick();
      n_checks++;
      if ({s, valid, fault, change} !== 6'b000_010) begin
        n_fail++;
        $display("FAIL fault_sticky edge=%0d got s/v/f/c=%b want %b", k, {s, valid, fault, change}, 6'b000_010);
      end
    end
    @(negedge clk); fault_clr = 1;
    tick();
    n_checks++;
    if ({s, valid, fault, change} !== 6'b011_101) begin
      n_fail++;
      $display("FAIL fault_recover got s/v/f/c=%b want %b", {s, valid, fault, change}, 6'b011_101);
    end
    @(negedge clk); fault_clr = 0;
    tick();
    n_checks++;
    if ({s, valid, fault, change} !== 6'b011_100) begin
      n_fail++;
      $display("FAIL after_recover got s/v/f/c=%b want %b", {s, valid, fault, change}, 6'b011_100);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] exp;
    @(negedge clk); raw = 3'b101;
    for (int k = 0; k <= 7; k++) begin
      tick();
      exp = (k < 6) ? 6'b011_100 : 6'b011_000;
      n_checks++;
      if ({s, valid, fault, change} !== exp) begin
        n_fail++;
        $display("FAIL enter_hold edge=%0d got s/v/f/c=%b want %b", k, {s, valid, fault, change}, exp);
      end
    end
    @(negedge clk); reset = 1; raw = 3'b000;
    tick();
    n_checks++;
    if ({s, valid, fault, change} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL reset_mid_hold got s/v/f/c=%b want %b", {s, valid, fault, change}, 6'b0);
    end
    @(negedge clk); reset = 0;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = {3'b000, (n == 6), 1'b0, 1'b0};
      n_checks++;
      if ({s, valid, fault, change} !== exp) begin
        n_fail++;
        $display("FAIL reinit edge=%0d got s/v/f/c=%b want %b", n, {s, valid, fault, change}, exp);
      end
    end
  endtask

  // ---------------- random traffic vs model ----------------
  task automatic test_random();
    logic [2:0] legal_c [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    logic [2:0] illegal_c [4] = '{3'b010, 3'b100, 3'b101, 3'b110};
    logic [2:0] tgt = 3'b000;
    int hold_left = 0;
    int r;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) ? 1'b1 : ($urandom_range(0, 399) == 0);
      if (hold_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6)      tgt = legal_c[$urandom_range(0, 3)];
        else if (r < 8) tgt = illegal_c[$urandom_range(0, 3)];
        else            tgt = tgt ^ (3'b001 << $urandom_range(0, 2));
        hold_left = (r >= 8) ? $urandom_range(1, 4) : $urandom_range(1, 16);
      end
      raw = tgt;
      hold_left--;
      fault_clr = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(raw, fault_clr, reset);
      #1;
      n_checks++;
      if ({s, valid, fault, change} !== {m_s, m_valid, m_fault, m_change}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got s/v/f/c=%b want %b", cyc,
                 {s, valid, fault, change}, {m_s, m_valid, m_fault, m_change});
      end
`ifdef RESERVOIR_SENSOR_FILTER_STATS_EN
      n_checks++;
      if (glitch_cnt !== 8'(m_glitch)) begin
        n_fail++;
        $display("FAIL random_glitch_cnt cyc=%0d got %0d want %0d", cyc, glitch_cnt, m_glitch);
      end
`endif
    end
    @(negedge clk); reset = 0; fault_clr = 0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_hold_fault();
    test_fault_recover();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
